// File: rtl/vx_wnd_ptr_ctrl_pkg.sv
// Shared types and widths for the register-window pointer controller and
// the decode unit that consumes its CWP / offset / enable outputs.
package vx_wnd_ptr_ctrl_pkg;

  localparam int NUM_WARPS    = 4;
  localparam int NUM_WINDOWS  = 4;   // physical windows per warp, power of 2
  localparam int STACK_DEPTH  = 8;   // max logical call depth per warp
  localparam int OFS_W        = 5;

  localparam int NW_BITS      = $clog2(NUM_WARPS);
  localparam int WND_BITS     = $clog2(NUM_WINDOWS);
  localparam int DEP_BITS     = $clog2(STACK_DEPTH + 1);
  localparam int RES_BITS     = $clog2(NUM_WINDOWS + 1);
  localparam int STK_IDX_BITS = $clog2(STACK_DEPTH);

  typedef enum logic {
    WND_CALL = 1'b0,
    WND_RET  = 1'b1
  } wnd_evt_e;

  typedef enum logic [1:0] {
    WS_IDLE,
    WS_SPILL,
    WS_FILL
  } wnd_state_e;

  // Per-warp pointer state; the offset LIFO lives in its own sub-module.
  typedef struct packed {
    logic [WND_BITS-1:0] cwp;
    logic [DEP_BITS-1:0] depth;
    logic [RES_BITS-1:0] resident;
  } wnd_warp_t;

endpackage

// File: rtl/vx_wnd_ptr_ctrl_if.sv
// Bundle of the event, spill/fill and decode-export signals of the
// window pointer controller. slave = controller, master = environment.
interface vx_wnd_ptr_ctrl_if;
  import vx_wnd_ptr_ctrl_pkg::*;

  logic                          evt_valid;
  logic                          evt_ready;
  logic [NW_BITS-1:0]            evt_wid;
  logic                          evt_type;
  logic [OFS_W-1:0]              evt_offset;

  logic                          spill_valid;
  logic                          spill_ready;
  logic [NW_BITS-1:0]            spill_wid;
  logic [WND_BITS-1:0]           spill_wnd;

  logic                          fill_valid;
  logic                          fill_ready;
  logic [NW_BITS-1:0]            fill_wid;
  logic [WND_BITS-1:0]           fill_wnd;

  logic [NUM_WARPS*WND_BITS-1:0] cwp_o;
  logic [NUM_WARPS*OFS_W-1:0]    ofs_o;
  logic [NUM_WARPS-1:0]          wnd_en_o;
  logic                          err_o;
  logic [NW_BITS-1:0]            err_wid;

  modport slave (
    input  evt_valid, evt_wid, evt_type, evt_offset, spill_ready, fill_ready,
    output evt_ready, spill_valid, spill_wid, spill_wnd,
    output fill_valid, fill_wid, fill_wnd,
    output cwp_o, ofs_o, wnd_en_o, err_o, err_wid
  );

  modport master (
    output evt_valid, evt_wid, evt_type, evt_offset, spill_ready, fill_ready,
    input  evt_ready, spill_valid, spill_wid, spill_wnd,
    input  fill_valid, fill_wid, fill_wnd,
    input  cwp_o, ofs_o, wnd_en_o, err_o, err_wid
  );

endinterface

// File: rtl/vx_wnd_ptr_ctrl_ofs_stack.sv
// Per-warp LIFO of window base offsets. Top reads 0 when empty.
// The controller guarantees no push when full and no pop when empty.
module vx_wnd_ptr_ctrl_ofs_stack
  import vx_wnd_ptr_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             nRST,
  input  logic             push,
  input  logic             pop,
  input  logic [OFS_W-1:0] din,
  output logic [OFS_W-1:0] top_o
);

  logic [OFS_W-1:0]        mem_reg [STACK_DEPTH];
  logic [DEP_BITS-1:0]     ptr_reg;
  logic [STK_IDX_BITS-1:0] top_idx;

  assign top_idx = STK_IDX_BITS'(ptr_reg - 1'b1);
  assign top_o   = (ptr_reg != '0) ? mem_reg[top_idx] : '0;

  // Push writes at the current pointer; pop only moves the pointer.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ptr_reg <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem_reg[i] <= '0;
    end else if (push) begin
      mem_reg[ptr_reg[STK_IDX_BITS-1:0]] <= din;
      ptr_reg <= ptr_reg + 1'b1;
    end else if (pop) begin
      ptr_reg <= ptr_reg - 1'b1;
    end
  end

endmodule

// File: rtl/vx_wnd_ptr_ctrl.sv
// Per-warp register-window pointer controller: tracks CWP, call depth and
// resident windows, and sequences spill/fill when physical windows run out.
module vx_wnd_ptr_ctrl
  import vx_wnd_ptr_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               nRST,
  vx_wnd_ptr_ctrl_if.slave   bus
);

  wnd_state_e         state_reg, state_next;
  wnd_warp_t          warp_reg [NUM_WARPS];
  logic [NW_BITS-1:0] lat_wid_reg;
  logic [OFS_W-1:0]   lat_ofs_reg;
  logic               err_reg, err_next;
  logic [NW_BITS-1:0] err_wid_reg;

  logic               latch_en, do_call, do_ret, keep_res;
  logic [NW_BITS-1:0] cmd_wid;
  logic [OFS_W-1:0]   cmd_ofs;
  logic [NUM_WARPS-1:0] push_w, pop_w;
  logic [OFS_W-1:0]   top_ofs [NUM_WARPS];
  logic [NUM_WARPS*WND_BITS-1:0] cwp_vec;
  logic [NUM_WARPS*OFS_W-1:0]    ofs_vec;

  // Next state and commit decisions; the spill/fill completion re-issues the
  // latched event with the resident count left unchanged.
  always_comb begin
    state_next = state_reg;
    latch_en   = 1'b0;
    do_call    = 1'b0;
    do_ret     = 1'b0;
    keep_res   = 1'b0;
    err_next   = 1'b0;
    cmd_wid    = bus.evt_wid;
    cmd_ofs    = bus.evt_offset;
    case (state_reg)
      WS_IDLE: begin
        if (bus.evt_valid) begin
          if (bus.evt_type == WND_CALL) begin
            if (warp_reg[bus.evt_wid].depth == DEP_BITS'(STACK_DEPTH)) begin
              err_next = 1'b1;
            end else if (warp_reg[bus.evt_wid].resident < RES_BITS'(NUM_WINDOWS)) begin
              do_call = 1'b1;
            end else begin
              latch_en   = 1'b1;
              state_next = WS_SPILL;
            end
          end else begin
            if (warp_reg[bus.evt_wid].depth == '0) begin
              err_next = 1'b1;
            end else if (warp_reg[bus.evt_wid].resident > RES_BITS'(1)) begin
              do_ret = 1'b1;
            end else begin
              latch_en   = 1'b1;
              state_next = WS_FILL;
            end
          end
        end
      end
      WS_SPILL: begin
        cmd_wid = lat_wid_reg;
        cmd_ofs = lat_ofs_reg;
        if (bus.spill_ready) begin
          do_call    = 1'b1;
          keep_res   = 1'b1;
          state_next = WS_IDLE;
        end
      end
      WS_FILL: begin
        cmd_wid = lat_wid_reg;
        cmd_ofs = lat_ofs_reg;
        if (bus.fill_ready) begin
          do_ret     = 1'b1;
          keep_res   = 1'b1;
          state_next = WS_IDLE;
        end
      end
      default: state_next = WS_IDLE;
    endcase
  end

  // FSM state, latched event and error pulse registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_reg   <= WS_IDLE;
      lat_wid_reg <= '0;
      lat_ofs_reg <= '0;
      err_reg     <= 1'b0;
      err_wid_reg <= '0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      if (latch_en) begin
        lat_wid_reg <= bus.evt_wid;
        lat_ofs_reg <= bus.evt_offset;
      end
      if (err_next) err_wid_reg <= bus.evt_wid;
    end
  end

  // Per-warp pointer state update on committed CALL/RET.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        warp_reg[w].cwp      <= '0;
        warp_reg[w].depth    <= '0;
        warp_reg[w].resident <= RES_BITS'(1);
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (do_call && cmd_wid == NW_BITS'(w)) begin
          warp_reg[w].cwp   <= warp_reg[w].cwp + 1'b1;
          warp_reg[w].depth <= warp_reg[w].depth + 1'b1;
          if (!keep_res) warp_reg[w].resident <= warp_reg[w].resident + 1'b1;
        end else if (do_ret && cmd_wid == NW_BITS'(w)) begin
          warp_reg[w].cwp   <= warp_reg[w].cwp - 1'b1;
          warp_reg[w].depth <= warp_reg[w].depth - 1'b1;
          if (!keep_res) warp_reg[w].resident <= warp_reg[w].resident - 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
    assign push_w[gi] = do_call && (cmd_wid == NW_BITS'(gi));
    assign pop_w[gi]  = do_ret  && (cmd_wid == NW_BITS'(gi));

    vx_wnd_ptr_ctrl_ofs_stack u_stack (
      .clk   (clk),
      .nRST  (nRST),
      .push  (push_w[gi]),
      .pop   (pop_w[gi]),
      .din   (cmd_ofs),
      .top_o (top_ofs[gi])
    );

    assign cwp_vec[gi*WND_BITS +: WND_BITS] = warp_reg[gi].cwp;
    assign ofs_vec[gi*OFS_W +: OFS_W]       = top_ofs[gi];
    assign bus.wnd_en_o[gi]                 = (warp_reg[gi].depth != '0);
  end

  assign bus.cwp_o       = cwp_vec;
  assign bus.ofs_o       = ofs_vec;
  assign bus.evt_ready   = nRST && (state_reg == WS_IDLE);
  assign bus.spill_valid = (state_reg == WS_SPILL);
  assign bus.spill_wid   = bus.spill_valid ? lat_wid_reg : '0;
  assign bus.spill_wnd   = bus.spill_valid ? WND_BITS'(warp_reg[lat_wid_reg].cwp + 1'b1) : '0;
  assign bus.fill_valid  = (state_reg == WS_FILL);
  assign bus.fill_wid    = bus.fill_valid ? lat_wid_reg : '0;
  assign bus.fill_wnd    = bus.fill_valid ? WND_BITS'(warp_reg[lat_wid_reg].cwp - 1'b1) : '0;
  assign bus.err_o       = err_reg;
  assign bus.err_wid     = err_wid_reg;

endmodule

// File: tb/tb_vx_wnd_ptr_ctrl.sv
// Directed bench for the window pointer controller.
module tb_vx_wnd_ptr_ctrl;
  import vx_wnd_ptr_ctrl_pkg::*;

  logic clk  = 1'b0;
  logic nRST = 1'b0;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total    = 0;

  vx_wnd_ptr_ctrl_if bus ();

  vx_wnd_ptr_ctrl dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int wid, input logic typ, input int ofs);
    bus.evt_valid  = 1'b1;
    bus.evt_wid    = NW_BITS'(wid);
    bus.evt_type   = typ;
    bus.evt_offset = OFS_W'(ofs);
    tick();
    bus.evt_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!bus.evt_ready && n < 8) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.evt_ready), 32'd1);
  endtask

  function automatic logic [31:0] pk_cwp(input int c0, input int c1, input int c2, input int c3);
    logic [1:0] a, b, c, d;
    a = c0[1:0]; b = c1[1:0]; c = c2[1:0]; d = c3[1:0];
    return 32'({d, c, b, a});
  endfunction

  function automatic logic [31:0] pk_ofs(input int o0, input int o1, input int o2, input int o3);
    logic [4:0] a, b, c, d;
    a = o0[4:0]; b = o1[4:0]; c = o2[4:0]; d = o3[4:0];
    return 32'({d, c, b, a});
  endfunction

  initial begin
    bus.evt_valid = 1'b0; bus.evt_wid = '0; bus.evt_type = 1'b0; bus.evt_offset = '0;
    bus.spill_ready = 1'b0; bus.fill_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_evt_ready", 32'(bus.evt_ready), 32'd0);
    chk("rst_cwp", 32'(bus.cwp_o), 32'd0);
    chk("rst_ofs", 32'(bus.ofs_o), 32'd0);
    chk("rst_wnd_en", 32'(bus.wnd_en_o), 32'd0);
    chk("rst_spill", 32'(bus.spill_valid), 32'd0);
    nRST = 1'b1;
    #1;
    chk("rel_evt_ready", 32'(bus.evt_ready), 32'd1);
    $display("reset released");

    // Single CALL on warp 1
    send(1, WND_CALL, 3);
    chk("call1_cwp", 32'(bus.cwp_o), pk_cwp(0, 1, 0, 0));
    chk("call1_ofs", 32'(bus.ofs_o), pk_ofs(0, 3, 0, 0));
    chk("call1_en", 32'(bus.wnd_en_o), 32'b0010);
    $display("CALL w1 ofs3 cwp_o=%h ofs_o=%h", bus.cwp_o, bus.ofs_o);

    // Warp 0: three direct CALLs fill the physical windows
    for (int i = 1; i <= 3; i++) begin
      send(0, WND_CALL, i);
      chk("w0_call_cwp", 32'(bus.cwp_o), pk_cwp(i, 1, 0, 0));
      chk("w0_call_ofs", 32'(bus.ofs_o), pk_ofs(i, 3, 0, 0));
      $display("CALL w0 ofs%0d cwp_o=%h", i, bus.cwp_o);
    end

    // Fourth CALL must spill the oldest window (cwp+1 = 0)
    send(0, WND_CALL, 4);
    chk("spill_valid", 32'(bus.spill_valid), 32'd1);
    chk("spill_wid", 32'(bus.spill_wid), 32'd0);
    chk("spill_wnd", 32'(bus.spill_wnd), 32'd0);
    chk("spill_evt_ready", 32'(bus.evt_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("spill_hold_valid", 32'(bus.spill_valid), 32'd1);
      chk("spill_hold_wnd", 32'(bus.spill_wnd), 32'd0);
      chk("spill_hold_cwp", 32'(bus.cwp_o), pk_cwp(3, 1, 0, 0));
    end
    bus.spill_ready = 1'b1;
    tick();
    bus.spill_ready = 1'b0;
    chk("spill_done_cwp", 32'(bus.cwp_o), pk_cwp(0, 1, 0, 0));
    chk("spill_done_ofs", 32'(bus.ofs_o), pk_ofs(4, 3, 0, 0));
    chk("spill_done_valid", 32'(bus.spill_valid), 32'd0);
    chk("spill_done_ready", 32'(bus.evt_ready), 32'd1);
    $display("SPILL w0 done cwp_o=%h ofs_o=%h", bus.cwp_o, bus.ofs_o);

    // Three RETs without fill: cwp 3,2,1 and top offsets 3,2,1
    for (int i = 3; i >= 1; i--) begin
      send(0, WND_RET, 0);
      chk("ret_cwp", 32'(bus.cwp_o), pk_cwp(i, 1, 0, 0));
      chk("ret_ofs", 32'(bus.ofs_o), pk_ofs(i, 3, 0, 0));
      chk("ret_nofill", 32'(bus.fill_valid), 32'd0);
      $display("RET w0 cwp_o=%h ofs_o=%h", bus.cwp_o, bus.ofs_o);
    end

    // Fourth RET with one resident window needs a fill of window cwp-1 = 0
    send(0, WND_RET, 0);
    chk("fill_valid", 32'(bus.fill_valid), 32'd1);
    chk("fill_wid", 32'(bus.fill_wid), 32'd0);
    chk("fill_wnd", 32'(bus.fill_wnd), 32'd0);
    tick();
    chk("fill_hold_wnd", 32'(bus.fill_wnd), 32'd0);
    bus.fill_ready = 1'b1;
    tick();
    bus.fill_ready = 1'b0;
    chk("fill_done_cwp", 32'(bus.cwp_o), pk_cwp(0, 1, 0, 0));
    chk("fill_done_en", 32'(bus.wnd_en_o), 32'b0010);
    chk("fill_done_ofs", 32'(bus.ofs_o), pk_ofs(0, 3, 0, 0));
    chk("fill_done_valid", 32'(bus.fill_valid), 32'd0);
    $display("FILL w0 done cwp_o=%h en=%b", bus.cwp_o, bus.wnd_en_o);

    // Underflow on warp 2
    send(2, WND_RET, 0);
    chk("udf_err", 32'(bus.err_o), 32'd1);
    chk("udf_wid", 32'(bus.err_wid), 32'd2);
    chk("udf_cwp", 32'(bus.cwp_o), pk_cwp(0, 1, 0, 0));
    tick();
    chk("udf_pulse", 32'(bus.err_o), 32'd0);
    chk("udf_en", 32'(bus.wnd_en_o), 32'b0010);
    $display("RET w2 at depth0 -> underflow");

    // Warp 3: eight CALLs (spills acknowledged immediately), then overflow
    bus.spill_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(3, WND_CALL, i + 10);
      wait_idle("w3_call_idle");
      $display("CALL w3 ofs%0d cwp_o=%h", i + 10, bus.cwp_o);
    end
    chk("w3_full_cwp", 32'(bus.cwp_o), pk_cwp(0, 1, 0, 0));
    chk("w3_full_ofs", 32'(bus.ofs_o), pk_ofs(0, 3, 0, 18));
    chk("w3_full_en", 32'(bus.wnd_en_o), 32'b1010);
    send(3, WND_CALL, 25);
    chk("ovf_err", 32'(bus.err_o), 32'd1);
    chk("ovf_wid", 32'(bus.err_wid), 32'd3);
    chk("ovf_cwp", 32'(bus.cwp_o), pk_cwp(0, 1, 0, 0));
    chk("ovf_ofs", 32'(bus.ofs_o), pk_ofs(0, 3, 0, 18));
    chk("ovf_nospill", 32'(bus.spill_valid), 32'd0);
    tick();
    chk("ovf_pulse", 32'(bus.err_o), 32'd0);
    $display("CALL w3 at depth8 -> overflow");
    bus.spill_ready = 1'b0;

    // Reset while a spill is outstanding
    for (int i = 5; i <= 8; i++) send(0, WND_CALL, i);
    chk("rs_spill_valid", 32'(bus.spill_valid), 32'd1);
    chk("rs_spill_wnd", 32'(bus.spill_wnd), 32'd0);
    nRST = 1'b0;
    #1;
    chk("rs_spill_drop", 32'(bus.spill_valid), 32'd0);
    chk("rs_evt_ready", 32'(bus.evt_ready), 32'd0);
    tick(); tick();
    nRST = 1'b1;
    #1;
    chk("rs_cwp", 32'(bus.cwp_o), 32'd0);
    chk("rs_ofs", 32'(bus.ofs_o), 32'd0);
    chk("rs_en", 32'(bus.wnd_en_o), 32'd0);
    chk("rs_ready", 32'(bus.evt_ready), 32'd1);
    $display("reset during SPILL");
    send(0, WND_CALL, 9);
    chk("rs_call_cwp", 32'(bus.cwp_o), pk_cwp(1, 0, 0, 0));
    chk("rs_call_ofs", 32'(bus.ofs_o), pk_ofs(9, 0, 0, 0));
    $display("CALL w0 ofs9 after reset cwp_o=%h", bus.cwp_o);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
